// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator memory read path: default widths,
// the reader FSM state encoding and a byte-reversal helper.
package cnn_pkg;

  localparam int CNN_ADDR_W = 25;
  localparam int CNN_DATA_W = 32;
  localparam int CNN_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Reverses byte order; the lowest byte of the input becomes the highest.
  function automatic logic [CNN_DATA_W-1:0] byte_swap(input logic [CNN_DATA_W-1:0] d);
    logic [CNN_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < CNN_DATA_W / 8; i++) begin
      r[8*i +: 8] = d[CNN_DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_rd_fifo.sv
// Return-data buffer for cnn_mem_reader: synchronous FIFO with occupancy count.
// Push and pop in the same cycle are accepted at any occupancy.
module cnn_rd_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  // A pop frees the slot the simultaneous push lands in, so full+pop still writes.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_C) || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/cnn_mem_reader.sv
// CNN read master: fetches cmd_len words from cmd_base and streams them out with a last marker.
// Define CNN_RD_BYTESWAP_EN to byte-reverse every returned word before buffering.
module cnn_mem_reader
  import cnn_pkg::*;
#(
  parameter int ADDR_W     = CNN_ADDR_W,
  parameter int DATA_W     = CNN_DATA_W,
  parameter int LEN_W      = CNN_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  rd_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_pushed;
  logic [CW-1:0]     r_outstanding;
  logic              r_done;

  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_empty;
  logic [DATA_W:0]   w_fifo_head;
  logic [CW-1:0]     w_used;
  logic              w_credit;
  logic              w_grant;
  logic              w_rv_accept;
  logic              w_pop;
  logic              w_push_last;
  logic [DATA_W-1:0] w_rdata;

  // Every granted word holds a slot, either outstanding or buffered, until it pops.
  assign w_used      = w_fifo_count + r_outstanding;
  assign w_credit    = (w_used < DEPTH_C);
  assign mem_req     = (r_state == ST_ISSUE) && (r_issued < r_len) && w_credit;
  assign w_grant     = mem_req && mem_gnt;
  assign w_rv_accept = mem_rvalid && (r_outstanding != '0);
  assign w_pop       = out_valid && out_ready;
  assign w_push_last = (r_pushed == (r_len - LEN_ONE));

`ifdef CNN_RD_BYTESWAP_EN
  assign w_rdata = byte_swap(mem_rdata);
`else
  assign w_rdata = mem_rdata;
`endif

  cnn_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rv_accept),
    .i_data  ({w_push_last, w_rdata}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_valid = !w_fifo_empty;
  assign out_data  = out_valid ? w_fifo_head[DATA_W-1:0] : '0;
  assign out_last  = out_valid && w_fifo_head[DATA_W];
  assign mem_addr  = r_addr;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

  // Counter updates come first so a command acceptance in IDLE can clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_pushed      <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case ({w_grant, w_rv_accept})
        2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_rv_accept) r_pushed <= r_pushed + LEN_ONE;

      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr   <= cmd_base;
            r_len    <= cmd_len;
            r_issued <= '0;
            r_pushed <= '0;
            if (cmd_len != '0) r_state <= ST_ISSUE;
            else               r_done  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_grant) begin
            r_addr   <= r_addr + ADDR_ONE;
            r_issued <= r_issued + LEN_ONE;
            if ((r_issued + LEN_ONE) == r_len) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && out_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_mem_reader.sv
// Directed bench for cnn_mem_reader with a latency-configurable in-order memory model.
module tb_cnn_mem_reader;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [24:0] cmd_base;
  logic [15:0] cmd_len;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int passCount = 0;
  int failCount = 0;
  int totalCount = 0;

  int cyc = 0;
  int memLat = 1;
  bit gntRandom = 0;
  int readyMode = 0;

  logic [24:0] pendAddr[$];
  int          pendDue[$];
  logic [24:0] grAddr[$];
  int          grCyc[$];
  logic [31:0] rxData[$];
  logic        rxLast[$];

  int grants = 0;
  int pops = 0;
  int maxInflight = 0;
  int doneCount = 0;
  int doneStart = 0;
  int doneCyc = 0;
  int acceptCyc = 0;
  int stabErr = 0;
  bit prevPend = 0;
  logic [24:0] prevAddr = '0;
  bit busySeen = 0;
  bit notReadySeen = 0;

  cnn_mem_reader dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory contents: a recognisable pattern per address, plus one fixed word for the byte-order check.
  function automatic logic [31:0] memWord(input logic [24:0] a);
    if (a == 25'h401) return 32'h11223344;
    return {7'h52, a};
  endfunction

  function automatic logic [31:0] expWord(input logic [24:0] a);
    logic [31:0] w;
    w = memWord(a);
`ifdef CNN_RD_BYTESWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  // In-order memory: grant decided each cycle, data returned memLat cycles after the grant cycle.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        pendAddr.delete();
        pendDue.delete();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_gnt    = 1'b0;
      end else begin
        if (pendAddr.size() > 0 && pendDue[0] <= cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memWord(pendAddr[0]);
          void'(pendAddr.pop_front());
          void'(pendDue.pop_front());
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = '0;
        end
        mem_gnt = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_req && mem_gnt) begin
          pendAddr.push_back(mem_addr);
          pendDue.push_back(cyc + memLat);
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      grants   = 0;
      pops     = 0;
      prevPend = 0;
    end else begin
      if (prevPend && (!mem_req || mem_addr !== prevAddr)) stabErr++;
      prevPend = mem_req && !mem_gnt;
      prevAddr = mem_addr;
      if (cmd_valid && cmd_ready) acceptCyc = cyc;
      if (mem_req && mem_gnt) begin
        grants++;
        grAddr.push_back(mem_addr);
        grCyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        pops++;
        rxData.push_back(out_data);
        rxLast.push_back(out_last);
      end
      if (grants - pops > maxInflight) maxInflight = grants - pops;
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (busy) busySeen = 1;
      if (!cmd_ready) notReadySeen = 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [24:0] base, input logic [15:0] len);
    rxData.delete();
    rxLast.delete();
    grAddr.delete();
    grCyc.delete();
    maxInflight  = 0;
    busySeen     = 0;
    notReadySeen = 0;
    doneStart    = doneCount;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (doneCount == doneStart && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " done seen"}, 32'(doneCount != doneStart), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput({tag, " done pulses"}, 32'(doneCount - doneStart), 32'd1);
    checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
    checkOutput({tag, " cmd_ready after"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic checkRx(input string tag, input logic [24:0] base, input int len);
    logic [24:0] a;
    checkOutput({tag, " word count"}, 32'(rxData.size()), 32'(len));
    for (int i = 0; i < len && i < rxData.size(); i++) begin
      a = base + 25'(i);
      checkOutput($sformatf("%s data[%0d]", tag, i), rxData[i], expWord(a));
      checkOutput($sformatf("%s last[%0d]", tag, i), 32'(rxLast[i]), 32'(i == len - 1));
    end
  endtask

  task automatic checkGrants(input string tag, input logic [24:0] base, input int len);
    logic [24:0] a;
    checkOutput({tag, " grant count"}, 32'(grAddr.size()), 32'(len));
    for (int i = 0; i < len && i < grAddr.size(); i++) begin
      a = base + 25'(i);
      checkOutput($sformatf("%s addr[%0d]", tag, i), 32'(grAddr[i]), 32'(a));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, " mem_req"},   32'(mem_req),   32'd0);
    checkOutput({tag, " mem_addr"},  32'(mem_addr),  32'd0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " out_data"},  out_data,       32'd0);
    checkOutput({tag, " out_last"},  32'(out_last),  32'd0);
    checkOutput({tag, " busy"},      32'(busy),      32'd0);
    checkOutput({tag, " done"},      32'(done),      32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] test 1: base 0x10 len 8 zero-wait memory");
    memLat = 1;
    applyStimulus(25'h10, 16'd8);
    waitDone("t1", 200);
    checkGrants("t1", 25'h10, 8);
    if (grCyc.size() > 0) checkOutput("t1 first req cycle", 32'(grCyc[0]), 32'(acceptCyc + 1));
    for (int i = 1; i < grCyc.size(); i++) begin
      checkOutput($sformatf("t1 grant cycle[%0d]", i), 32'(grCyc[i]), 32'(grCyc[0] + i));
    end
    checkRx("t1", 25'h10, 8);

    $display("[TB] test 2: zero-length command");
    applyStimulus(25'h50, 16'd0);
    waitDone("t2", 20);
    checkOutput("t2 done latency", 32'(doneCyc - acceptCyc), 32'd1);
    checkOutput("t2 no requests", 32'(grAddr.size()), 32'd0);
    checkOutput("t2 busy seen", 32'(busySeen), 32'd0);
    checkOutput("t2 cmd_ready dropped", 32'(notReadySeen), 32'd0);

    $display("[TB] test 3: latency 10 len 16");
    memLat = 10;
    applyStimulus(25'h100, 16'd16);
    waitDone("t3", 600);
    checkOutput("t3 max in flight", 32'(maxInflight), 32'd4);
    checkGrants("t3", 25'h100, 16);
    checkRx("t3", 25'h100, 16);

    $display("[TB] test 4: backpressure len 12");
    memLat    = 3;
    readyMode = 2;
    applyStimulus(25'h200, 16'd12);
    repeat (20) @(negedge clk);
    checkOutput("t4 req stalled", 32'(mem_req), 32'd0);
    checkOutput("t4 fifo holding", 32'(out_valid), 32'd1);
    checkOutput("t4 grants while stalled", 32'(grAddr.size()), 32'd4);
    readyMode = 1;
    gntRandom = 1;
    waitDone("t4", 1500);
    gntRandom = 0;
    readyMode = 0;
    checkOutput("t4 max in flight", 32'(maxInflight), 32'd4);
    checkOutput("t4 req stability", 32'(stabErr), 32'd0);
    checkGrants("t4", 25'h200, 12);
    checkRx("t4", 25'h200, 12);

    $display("[TB] test 5: address wrap");
    memLat = 1;
    applyStimulus(25'h1FF_FFFE, 16'd4);
    waitDone("t5", 100);
    checkGrants("t5", 25'h1FF_FFFE, 4);
    checkRx("t5", 25'h1FF_FFFE, 4);

    $display("[TB] test 6: reset mid-command then restart");
    applyStimulus(25'h300, 16'd8);
    n = 0;
    while (rxData.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6 three delivered", 32'(rxData.size()), 32'd3);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkResetValues("t6 reset");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(25'h400, 16'd2);
    waitDone("t6", 100);
    checkGrants("t6", 25'h400, 2);
    checkRx("t6", 25'h400, 2);
    checkOutput("t6 final req stability", 32'(stabErr), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/cnn_mem_reader.md
# cnn_mem_reader

Read master that fetches 32-bit words from the image or weight RAM for the CNN accelerator and streams them to the compute datapath. It accepts a command (base word address, word count), issues pipelined memory reads with a request/grant handshake, buffers returning data in a small credit-controlled FIFO, and presents it on a valid/ready stream with a last marker. It is the consumer end of the word-addressed image/weight memory interface that the bench models with file-loaded RAMs.

## Interface
- ADDR_W, 25, word-address width (covers the 32M-word weight RAM)
- DATA_W, 32, data word width
- LEN_W, 16, command length width in words
- FIFO_DEPTH, 4, return-buffer entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  LEN_W  number of words to read
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read word address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data returned, in request order
- mem_rdata  in  DATA_W  read data
- out_valid  out  1  stream word available
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  stream word
- out_last  out  1  final word of the command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid: latch base/len, clear counters. If len≠0, go to ISSUE; else pulse done next cycle and stay in IDLE.
- ISSUE: mem_req=1 while issued<len and credits>0. Credits = FIFO_DEPTH − (FIFO occupancy + outstanding). Each mem_req&mem_gnt: addr+1 (wraps mod 2^ADDR_W), issued+1, outstanding+1. After the final grant, go to DRAIN.
- Each mem_rvalid pushes one word into the FIFO and decrements outstanding. The FIFO can never overflow, by construction. mem_rvalid with outstanding=0 is ignored.
- out_valid = FIFO non-empty. A pop happens on out_valid&out_ready. A push and a pop in the same cycle are legal at any occupancy, including full and empty.
- out_last=1 on the word whose delivered count equals len−1.
- DRAIN: when the last word pops, pulse done on the same edge the state returns to IDLE.
- busy=1 in ISSUE/DRAIN.
- mem_addr and mem_req hold stable until granted. mem_req never drops without a grant except on reset.
- Reset (any time, including mid-command): all state cleared immediately. Outstanding responses are abandoned; the memory side is reset by the same signal.

## Timing
- Reset values: cmd_ready=1, mem_req=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- Command accepted at edge N → mem_req high in cycle N+1.
- Back-to-back grants give one request per cycle until credits are exhausted.
- mem_rvalid at edge M → out_valid high after edge M (1-cycle registered FIFO write; head visible next cycle).
- Sustained throughput is 1 word/cycle when the memory read latency is < FIFO_DEPTH cycles and out_ready=1.
- done pulses for exactly one cycle. cmd_ready returns the same cycle as done.

## Configuration
- CNN_RD_BYTESWAP_EN defined: each mem_rdata word is byte-reversed ({b0,b1,b2,b3}) before the FIFO write, matching little-endian file images.
- Undefined: data passes unchanged.

## Structure
- Shared package cnn_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN)
  - default ADDR_W/DATA_W/LEN_W constants
  - a byte-swap function
- One sub-module: cnn_rd_fifo (synchronous FIFO, DATA_W+1 wide, storing the last flag, with count output).

## Test plan
- cmd_base=0x10, cmd_len=8, zero-wait memory (gnt=1, 1-cycle rvalid), out_ready=1 → addresses 0x10–0x17 issued on consecutive cycles; 8 words out in order; out_last on the 8th; one done pulse.
- cmd_len=0 → no mem_req; done 1 cycle after acceptance; cmd_ready stays high.
- Memory latency 10 cycles, FIFO_DEPTH=4, cmd_len=16 → outstanding never exceeds 4; no data lost; all 16 words delivered.
- out_ready toggled randomly / held low 20 cycles, cmd_len=12 → mem_req stalls when credits=0; the sequence out is unchanged.
- cmd_base=2^ADDR_W−2, cmd_len=4 → addresses ...FFE, ...FFF, 0, 1.
- Reset asserted after 3 of 8 words delivered → all outputs at reset values immediately. A new command of cmd_len=2 then completes normally. With CNN_RD_BYTESWAP_EN, rdata 0x11223344 appears as 0x44332211.
